// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants and FSM state encoding for the ALU arbiter.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters: add (wrapping) and bitwise or.
module ALU16bit
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic [OPW-1:0]   aluOp,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  output logic [WIDTH-1:0] outPut,
  output logic             isZero
);

  // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
  always_comb begin
    outPut = '0;
    if (aluOp == OPW'(ALU_ADD)) begin
      outPut = aIn + bIn;
    end else if (aluOp == OPW'(ALU_OR)) begin
      outPut = aIn | bIn;
    end
  end

  assign isZero = (outPut == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters; IDLE -> EXEC -> WRITE per operation.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [OPW-1:0]   op0,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  state_e           state_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             owner_q, last_grant_q;
  logic             gnt0_q, gnt1_q, done0_q, done1_q, busy_q, zero_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             any_req_d, win1_d;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    any_req_d = req0 | req1;
    win1_d    = req1 & (~req0 | ~last_grant_q);
  end

  ALU16bit #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .aluOp  (op_q),
    .aIn    (a_q),
    .bIn    (b_q),
    .outPut (alu_out),
    .isZero (alu_zero)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_WRITE: begin
          if (any_req_d) begin
            op_q         <= win1_d ? op1 : op0;
            a_q          <= win1_d ? a1 : a0;
            b_q          <= win1_d ? b1 : b0;
            gnt0_q       <= ~win1_d;
            gnt1_q       <= win1_d;
            owner_q      <= win1_d;
            last_grant_q <= win1_d;
            busy_q       <= 1'b1;
            state_q      <= ST_EXEC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          result_q <= alu_out;
          zero_q   <= alu_zero;
          done0_q  <= ~owner_q;
          done1_q  <= owner_q;
          busy_q   <= 1'b1;
          state_q  <= ST_WRITE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign busy   = busy_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule
